ahb_bridge_arbiter: RTL
=======================

// Module: ahb_bridge_arbiter
// PURPOSE
//  Round-robin AHB-Lite multi-master arbiter/mux in front of the ahb2apb_bridge AHB slave port.
//  Lets NUM_MST requesters (CPU, DMA, debug) share the single bridge, and tracks the address and data phases separately.
//  Decodes the bridge window; accesses outside it are answered by a built-in default slave with a 2-cycle ERROR.
// PARAMETERS
//  NUM_MST    2            number of masters (2..4)
//  AW         32           address width
//  DW         32           data width
//  MAX_HOLD   4            max consecutive NONSEQ transfers one master keeps the bus while others request
//  APB_BASE   32'h4000_0000  bridge window base (aligned to APB_SIZE)
//  APB_SIZE   32'h0001_0000  bridge window size in bytes (power of 2)
// PORTS
//  HCLK        in   1           clock, rising edge
//  HRESET      in   1           synchronous, active-high reset
//  M_HBUSREQ   in   NUM_MST     per-master bus request
//  M_HGRANT    out  NUM_MST     one-hot grant
//  M_HADDR     in   NUM_MST*AW  per-master address, packed (master i at [i*AW+:AW])
//  M_HTRANS    in   NUM_MST*2   per-master HTRANS
//  M_HWRITE    in   NUM_MST     per-master HWRITE
//  M_HSIZE     in   NUM_MST*3   per-master HSIZE
//  M_HPROT     in   NUM_MST*4   per-master HPROT
//  M_HWDATA    in   NUM_MST*DW  per-master write data (data phase)
//  HMASTER     out  2           index of the address-phase owner
//  HREADY      out  1           merged ready, broadcast to all masters and fed to the bridge HREADY
//  HRDATA      out  DW          read data, broadcast to masters
//  HRESP       out  1           response, broadcast to masters
//  S_HSEL, S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE, S_HPROT   out  1/AW/2/1/3/4  address phase to bridge
//  S_HWDATA    out  DW          data-phase write data to bridge
//  S_HREADYOUT in   1           bridge ready
//  S_HRDATA    in   DW          bridge read data
//  S_HRESP     in   1           bridge response
// BEHAVIOUR
//  Reset values:
//   - M_HGRANT=1 (master 0 is the default master); HMASTER=0; data_owner=0; hold_cnt=0.
//   - Default-slave FSM in DS_IDLE; HREADY=1; HRESP=0.
//  Address phase (combinational):
//   - Bus fields = fields of master HMASTER.
//   - If the owner's HBUSREQ=0 and it is still granted, S_HTRANS is forced to IDLE (2'b00).
//  Decode:
//   - hit = (S_HADDR & ~(APB_SIZE-1)) == APB_BASE.
//   - S_HSEL = hit & S_HTRANS[1].
//   - A miss with S_HTRANS[1]=1 and HREADY=1 arms the default slave.
//  Data phase:
//   - On HREADY=1, register data_owner<=HMASTER and ds_sel<=miss.
//   - S_HWDATA = M_HWDATA[data_owner].
//   - HREADY/HRDATA/HRESP come from the bridge, or from the default slave when ds_sel=1.
//  Default slave FSM (DS_IDLE -> DS_ERR1 -> DS_ERR2 -> DS_IDLE):
//   - DS_ERR1: HREADY=0, HRESP=1.
//   - DS_ERR2: HREADY=1, HRESP=1, HRDATA=0.
//   - Bridge S_HRESP=1 is passed through unchanged.
//  Arbitration point: HREADY=1 and one of
//   - (a) owner HTRANS is IDLE;
//   - (b) owner HBUSREQ=0;
//   - (c) owner HTRANS=NONSEQ, hold_cnt==MAX_HOLD-1 and another master requests.
//   - Never while the owner's HTRANS is SEQ or BUSY; bursts are not broken.
//  Grant selection:
//   - At an arbitration point, the next grant is the first requesting master after HMASTER in round-robin order.
//   - If nobody requests, grant goes to master 0. If only the owner requests, the owner keeps the grant.
//   - M_HGRANT and HMASTER update on the same edge, so grant is registered with 1-cycle latency.
//  hold_cnt:
//   - +1 per accepted NONSEQ (HREADY=1) by the same owner.
//   - Cleared on an owner change.
//   - Saturates at MAX_HOLD-1.
//  Simultaneous requests: the round-robin pointer alone resolves them; no fixed priority except the idle fallback to master 0.
//  Wait states (S_HREADYOUT=0): grant, HMASTER, data_owner and hold_cnt all hold.
//  Reset mid-transfer: all state returns to reset values on the next edge. An in-flight data phase is dropped; the bridge is reset by the same system.
//  HREADY=0 blocks both arbitration and the address-phase update (AHB pipelining rule).
// STRUCTURE
//  ahb_arb_pkg:
//   - HTRANS_IDLE/BUSY/NONSEQ/SEQ localparams.
//   - ds_state_e enum {DS_IDLE, DS_ERR1, DS_ERR2}.
//   - Function onehot2idx.
//  Sub-module rr_arbiter: combinational; inputs req[NUM_MST] and last[1:0]; outputs next one-hot.
//  Top-level contents: grant registers, hold counter, phase trackers, decode, default-slave FSM, muxes.
// TESTING
//  - Reset release, no requests -> M_HGRANT=4'b0001 and S_HTRANS=IDLE; HREADY=1 and HRESP=0 throughout.
//  - M0 and M1 request together from reset, each issuing NONSEQ writes to 0x4000_0010 -> M0 keeps the bus for 4 transfers, then M1 is granted. S_HWDATA tracks data_owner, with a 1-cycle lag after HMASTER changes.
//  - M1 performs INCR4 SEQ burst to 0x4000_0100 while M0 requests -> no grant change until the final SEQ completes; M0 is granted on the next edge.
//  - M0 reads 0x5000_0000 (miss) -> S_HSEL=0; next 2 cycles: HREADY=0/HRESP=1, then HREADY=1/HRESP=1; the bridge sees no PSEL.
//  - Bridge inserts 3 wait states (S_HREADYOUT=0) while M2 requests -> HMASTER, M_HGRANT and data_owner frozen; arbitration resumes on the HREADY=1 cycle.
//  - HRESET asserted mid-burst by M1 -> on the next edge M_HGRANT=0001, HMASTER=0, FSM in DS_IDLE and hold_cnt=0.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the AHB-Lite bridge arbiter.
// HTRANS encodings, default-slave states, one-hot decode.
package ahb_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_state_e;

    function automatic logic [1:0] onehot2idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last.
// Falls back to master 0 when nobody requests.
module rr_arbiter #(
    parameter int NUM_MST = 2
) (
    input  logic [NUM_MST-1:0] req,
    input  logic [1:0]         last,
    output logic [NUM_MST-1:0] next_oh
);

    localparam int IW = (NUM_MST > 2) ? 2 : 1;

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        next_oh = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= NUM_MST; i++) begin
            idx = IW'((int'(last) + i) % NUM_MST);
            if (!found && req[idx]) begin
                next_oh[idx] = 1'b1;
                found        = 1'b1;
            end
        end
        if (!found) next_oh[0] = 1'b1;
    end

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// Round-robin AHB-Lite multi-master arbiter in front of the APB bridge,
// with window decode and a 2-cycle ERROR default slave for misses.
module ahb_bridge_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int          NUM_MST  = 2,
    parameter int          AW       = 32,
    parameter int          DW       = 32,
    parameter int          MAX_HOLD = 4,
    parameter logic [31:0] APB_BASE = 32'h4000_0000,
    parameter logic [31:0] APB_SIZE = 32'h0001_0000
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [NUM_MST-1:0]    M_HBUSREQ,
    output logic [NUM_MST-1:0]    M_HGRANT,
    input  logic [NUM_MST*AW-1:0] M_HADDR,
    input  logic [NUM_MST*2-1:0]  M_HTRANS,
    input  logic [NUM_MST-1:0]    M_HWRITE,
    input  logic [NUM_MST*3-1:0]  M_HSIZE,
    input  logic [NUM_MST*4-1:0]  M_HPROT,
    input  logic [NUM_MST*DW-1:0] M_HWDATA,
    output logic [1:0]            HMASTER,
    output logic                  HREADY,
    output logic [DW-1:0]         HRDATA,
    output logic                  HRESP,
    output logic                  S_HSEL,
    output logic [AW-1:0]         S_HADDR,
    output logic [1:0]            S_HTRANS,
    output logic                  S_HWRITE,
    output logic [2:0]            S_HSIZE,
    output logic [3:0]            S_HPROT,
    output logic [DW-1:0]         S_HWDATA,
    input  logic                  S_HREADYOUT,
    input  logic [DW-1:0]         S_HRDATA,
    input  logic                  S_HRESP
);

    localparam int IW = (NUM_MST > 2) ? 2 : 1;
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD - 1);
    localparam logic [AW-1:0] WIN_BASE = AW'(APB_BASE);
    localparam logic [AW-1:0] WIN_MASK = ~(AW'(APB_SIZE - 32'd1));

    logic [AW-1:0] m_addr  [NUM_MST];
    logic [1:0]    m_trans [NUM_MST];
    logic [2:0]    m_size  [NUM_MST];
    logic [3:0]    m_prot  [NUM_MST];
    logic [DW-1:0] m_wdata [NUM_MST];

    for (genvar i = 0; i < NUM_MST; i++) begin : g_unpack
        assign m_addr[i]  = M_HADDR[i*AW +: AW];
        assign m_trans[i] = M_HTRANS[i*2 +: 2];
        assign m_size[i]  = M_HSIZE[i*3 +: 3];
        assign m_prot[i]  = M_HPROT[i*4 +: 4];
        assign m_wdata[i] = M_HWDATA[i*DW +: DW];
    end

    logic [IW-1:0]      own;
    logic [IW-1:0]      data_owner;
    logic [CW-1:0]      hold_cnt;
    logic               ds_sel;
    ds_state_e          ds_state;
    logic               ds_hready;
    logic               ds_hresp;
    logic [1:0]         own_trans;
    logic               own_req;
    logic               others_req;
    logic               in_burst;
    logic               hit;
    logic               miss_req;
    logic               arb_pt;
    logic [NUM_MST-1:0] nxt_grant;

    assign own       = HMASTER[IW-1:0];
    assign own_trans = m_trans[own];
    assign own_req   = M_HBUSREQ[own];

    // An owner that has dropped its request must not start new transfers.
    assign S_HADDR  = m_addr[own];
    assign S_HTRANS = own_req ? own_trans : HTRANS_IDLE;
    assign S_HWRITE = M_HWRITE[own];
    assign S_HSIZE  = m_size[own];
    assign S_HPROT  = m_prot[own];

    assign hit      = (S_HADDR & WIN_MASK) == WIN_BASE;
    assign S_HSEL   = hit & S_HTRANS[1];
    assign miss_req = ~hit & S_HTRANS[1];

    assign S_HWDATA = m_wdata[data_owner];
    assign HREADY   = ds_sel ? ds_hready : S_HREADYOUT;
    assign HRESP    = ds_sel ? ds_hresp  : S_HRESP;
    assign HRDATA   = ds_sel ? '0        : S_HRDATA;

    assign others_req = |(M_HBUSREQ & ~M_HGRANT);
    assign in_burst   = (own_trans == HTRANS_SEQ) ||
                        (own_trans == HTRANS_BUSY);

    always_comb begin
        arb_pt = 1'b0;
        if (HREADY && !in_burst) begin
            arb_pt = (own_trans == HTRANS_IDLE) || !own_req ||
                     ((own_trans == HTRANS_NONSEQ) &&
                      (hold_cnt == HOLD_MAX) && others_req);
        end
    end

    rr_arbiter #(
        .NUM_MST (NUM_MST)
    ) u_rr (
        .req     (M_HBUSREQ),
        .last    (HMASTER),
        .next_oh (nxt_grant)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            M_HGRANT   <= NUM_MST'(1);
            HMASTER    <= '0;
            data_owner <= '0;
            hold_cnt   <= '0;
            ds_sel     <= 1'b0;
        end else if (HREADY) begin
            data_owner <= own;
            ds_sel     <= miss_req;
            if (arb_pt) begin
                M_HGRANT <= nxt_grant;
                HMASTER  <= onehot2idx(4'(nxt_grant));
            end
            if (arb_pt && (nxt_grant != M_HGRANT)) begin
                hold_cnt <= '0;
            end else if ((S_HTRANS == HTRANS_NONSEQ) &&
                         (hold_cnt != HOLD_MAX)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    // Default slave: ERR1 stalls with HRESP, ERR2 completes the ERROR.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ds_state  <= DS_IDLE;
            ds_hready <= 1'b1;
            ds_hresp  <= 1'b0;
        end else begin
            unique case (ds_state)
                DS_IDLE, DS_ERR2: begin
                    if (miss_req && HREADY) begin
                        ds_state  <= DS_ERR1;
                        ds_hready <= 1'b0;
                        ds_hresp  <= 1'b1;
                    end else begin
                        ds_state  <= DS_IDLE;
                        ds_hready <= 1'b1;
                        ds_hresp  <= 1'b0;
                    end
                end
                DS_ERR1: begin
                    ds_state  <= DS_ERR2;
                    ds_hready <= 1'b1;
                    ds_hresp  <= 1'b1;
                end
                default: begin
                    ds_state  <= DS_IDLE;
                    ds_hready <= 1'b1;
                    ds_hresp  <= 1'b0;
                end
            endcase
        end
    end

endmodule
